am4_useq: RTL and testbench
===========================

// Module: am4_useq
// PURPOSE
//  Am2910-style microprogram sequencer for M4; directly upstream of mcrom.
//  Each enabled cycle: decodes sequencer field of current microword, drives addr (next address) into mcrom.
//  Holds uPC, loop counter R and LIFO subroutine stack.
// PARAMETERS
//  AW     10  microaddress width (matches mcrom addr)
//  SDEPTH 5   stack depth, entries
// PORTS
//  clk    in  1   system clock, rising edge
//  rst    in  1   synchronous reset, active-high
//  ena    in  1   clock enable; shared with mcrom ena
//  instr  in  4   sequencer opcode from microword
//  d      in  AW  direct/branch field from microword
//  map    in  AW  mapping address (opcode decoder)
//  vect   in  AW  interrupt vector address
//  cc     in  1   condition; pass = ~ccen | cc
//  ccen   in  1   condition enable; 1 = test cc, 0 = forced pass
//  ci     in  1   uPC increment carry; uPC <= addr + ci
//  rld    in  1   force R <= d this cycle, any opcode
//  addr   out AW  next microaddress to mcrom (combinational)
//  map_oe out 1   1 while instr == JMAP
//  vec_oe out 1   1 while instr == CJV
//  full   out 1   stack holds SDEPTH entries
// BEHAVIOUR
//  Registers update only on posedge clk with ena=1; ena=0 freezes all state.
//  rst: uPC=0, R=0, sp=0, every stack entry=0; addr forced to 0 while rst=1.
//  Fetch: mcrom latches rom[addr] on the same edge.
//  Latency: one microword per enabled cycle.
//  Every enabled cycle: uPC <= addr + ci (wraps modulo 2^AW).
//  R is AW bits: "R==0" tested before decrement; decrement never wraps below 0.
//  Opcodes, pass / fail:
//   0 JZ   addr=0; sp<=0
//   1 CJS  D, push uPC / uPC
//   2 JMAP map
//   3 CJP  D / uPC
//   4 PUSH uPC, push uPC; pass also loads R<=d
//   5 JSRP push uPC always; D / R
//   6 CJV  vect / uPC
//   7 JRP  D / R
//   8 RFCT R!=0: TOS, R-- ; R==0: uPC, pop
//   9 RPCT R!=0: D, R-- ; R==0: uPC
//   10 CRTN TOS, pop / uPC
//   11 CJPP D, pop / uPC
//   12 LDCT uPC; R<=d
//   13 LOOP uPC, pop / TOS
//   14 CONT uPC
//   15 TWB  R!=0: uPC, pop / TOS, R-- ; R==0: uPC, pop / D, pop
//  rld=1 overrides any R change from the opcode: R <= d.
//  Push semantics: TOS <= uPC (pre-update value); sp++.
//  Push with full=1: overwrite TOS, sp unchanged.
//  Pop with sp=0: no-op. TOS read with sp=0 returns 0.
//  JZ with simultaneous rld: sp<=0 and R<=d both take effect.
//  rst asserted mid-subroutine discards stack contents; next addr=0.
// CONFIGURATION
//  M4_USEQ_STKERR_EN defined:
//   adds output stk_err (1 bit), sticky.
//   Set on push while full=1 or pop while sp=0; cleared only by rst.
//  M4_USEQ_STKERR_EN undefined: no stk_err port; behaviour otherwise identical.
// STRUCTURE
//  Shared include am4_useq.vh: localparams for 16 opcodes (SEQ_JZ..SEQ_TWB) and AW default.
//  Sub-module am4_useq_stack: SDEPTH x AW LIFO.
//   Inputs: push, pop, clr, din. Outputs: tos, full, empty.
//  Top level holds uPC, R and the next-address mux.
// TESTING
//  rst=1, ena=1 -> addr=0, full=0; after release, CONT with ci=1 steps addr 0,1,2,3.
//  CJS pass, d=0x155 at uPC=0x010 -> addr=0x155, TOS=0x010; then CRTN pass -> addr=0x010, sp=0.
//  LDCT d=3, then RPCT d=0x020 -> addr=0x020 three times, then uPC; R ends at 0.
//  Six PUSHes with SDEPTH=5 -> full=1 after 5th; 6th overwrites TOS.
//   With M4_USEQ_STKERR_EN, stk_err=1 and stays 1 until rst.
//  CJV with ccen=1, cc=0 -> addr=uPC, vec_oe=1; same with cc=1 -> addr=vect.
//   JMAP -> addr=map, map_oe=1.
//  ena=0 for 4 cycles during RFCT loop -> uPC, R, sp and addr unchanged; loop resumes on ena=1.

Source files
------------

// File: rtl/am4_useq_pkg.sv
// Shared opcode encodings and default sizes for the microprogram sequencer.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package am4_useq_pkg;

    // Default microaddress width (matches mcrom addr) and stack depth
    localparam int AW_DEF     = 10;
    localparam int SDEPTH_DEF = 5;

    // Sequencer opcodes carried in the microword instr field
    localparam logic [3:0] SEQ_JZ   = 4'd0;
    localparam logic [3:0] SEQ_CJS  = 4'd1;
    localparam logic [3:0] SEQ_JMAP = 4'd2;
    localparam logic [3:0] SEQ_CJP  = 4'd3;
    localparam logic [3:0] SEQ_PUSH = 4'd4;
    localparam logic [3:0] SEQ_JSRP = 4'd5;
    localparam logic [3:0] SEQ_CJV  = 4'd6;
    localparam logic [3:0] SEQ_JRP  = 4'd7;
    localparam logic [3:0] SEQ_RFCT = 4'd8;
    localparam logic [3:0] SEQ_RPCT = 4'd9;
    localparam logic [3:0] SEQ_CRTN = 4'd10;
    localparam logic [3:0] SEQ_CJPP = 4'd11;
    localparam logic [3:0] SEQ_LDCT = 4'd12;
    localparam logic [3:0] SEQ_LOOP = 4'd13;
    localparam logic [3:0] SEQ_CONT = 4'd14;
    localparam logic [3:0] SEQ_TWB  = 4'd15;

    // Condition test: a cleared ccen forces a pass regardless of cc
    function automatic logic cond_pass(input logic ccen, input logic cc);
        return ~ccen | cc;
    endfunction

endpackage

// File: rtl/am4_useq_stack.sv
// SDEPTH x AW LIFO holding subroutine return / loop-start addresses.
// Latency: push/pop/clr take effect on the enabled edge; tos is combinational.
// Backpressure: none; push when full overwrites TOS, pop when empty is ignored.
module am4_useq_stack #(
    parameter int AW     = 10,
    parameter int SDEPTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          push,
    input  logic          pop,
    input  logic          clr,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] tos,
    output logic          full,
    output logic          empty
);

    localparam int SPW = $clog2(SDEPTH + 1);
    localparam int IW  = (SDEPTH > 1) ? $clog2(SDEPTH) : 1;

    logic [AW-1:0]  mem [SDEPTH];
    logic [SPW-1:0] sp;
    logic [IW-1:0]  top_idx;
    logic [IW-1:0]  wr_idx;

    assign full  = (sp == SPW'(SDEPTH));
    assign empty = (sp == '0);

    // Top entry sits one below sp; a push onto a full stack reuses the top slot
    assign top_idx = IW'(sp - SPW'(1));
    assign wr_idx  = full ? IW'(SDEPTH - 1) : IW'(sp);

    // An empty stack reads as address 0 rather than a stale entry
    assign tos = empty ? '0 : mem[top_idx];

    // Stack pointer and storage; clr only rewinds sp, rst also zeroes entries
    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
            for (int i = 0; i < SDEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (ena) begin
            if (clr) begin
                sp <= '0;
            end else if (push) begin
                mem[wr_idx] <= din;
                if (!full) begin
                    sp <= sp + SPW'(1);
                end
            end else if (pop && !empty) begin
                sp <= sp - SPW'(1);
            end
        end
    end

endmodule

// File: rtl/am4_useq.sv
// Am2910-style microprogram sequencer: uPC, loop counter R, LIFO stack, next-address mux.
// Latency: addr is combinational from the current microword; state advances one step per enabled cycle.
// Backpressure: ena=0 freezes all state; optional sticky stk_err when M4_USEQ_STKERR_EN is defined.
module am4_useq
    import am4_useq_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int SDEPTH = SDEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic [3:0]    instr,
    input  logic [AW-1:0] d,
    input  logic [AW-1:0] map,
    input  logic [AW-1:0] vect,
    input  logic          cc,
    input  logic          ccen,
    input  logic          ci,
    input  logic          rld,
    output logic [AW-1:0] addr,
    output logic          map_oe,
    output logic          vec_oe,
    output logic          full
`ifdef M4_USEQ_STKERR_EN
    ,
    output logic          stk_err
`endif
);

    logic [AW-1:0] upc;
    logic [AW-1:0] r;
    logic [AW-1:0] tos;
    logic [AW-1:0] nxt;
    logic          empty;
    logic          pass;
    logic          r_zero;
    logic          stk_push;
    logic          stk_pop;
    logic          stk_clr;
    logic          r_load;
    logic          r_dec;

    assign pass   = cond_pass(ccen, cc);
    assign r_zero = (r == '0);

    // Decode the opcode into next address plus stack and counter actions
    always_comb begin
        nxt      = upc;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_clr  = 1'b0;
        r_load   = 1'b0;
        r_dec    = 1'b0;
        case (instr)
            SEQ_JZ: begin
                nxt     = '0;
                stk_clr = 1'b1;
            end
            SEQ_CJS: begin
                if (pass) begin
                    nxt      = d;
                    stk_push = 1'b1;
                end
            end
            SEQ_JMAP: nxt = map;
            SEQ_CJP: begin
                if (pass) nxt = d;
            end
            SEQ_PUSH: begin
                stk_push = 1'b1;
                r_load   = pass;
            end
            SEQ_JSRP: begin
                stk_push = 1'b1;
                nxt      = pass ? d : r;
            end
            SEQ_CJV: begin
                if (pass) nxt = vect;
            end
            SEQ_JRP: nxt = pass ? d : r;
            SEQ_RFCT: begin
                if (!r_zero) begin
                    nxt   = tos;
                    r_dec = 1'b1;
                end else begin
                    stk_pop = 1'b1;
                end
            end
            SEQ_RPCT: begin
                if (!r_zero) begin
                    nxt   = d;
                    r_dec = 1'b1;
                end
            end
            SEQ_CRTN: begin
                if (pass) begin
                    nxt     = tos;
                    stk_pop = 1'b1;
                end
            end
            SEQ_CJPP: begin
                if (pass) begin
                    nxt     = d;
                    stk_pop = 1'b1;
                end
            end
            SEQ_LDCT: r_load = 1'b1;
            SEQ_LOOP: begin
                if (pass) stk_pop = 1'b1;
                else      nxt     = tos;
            end
            SEQ_CONT: nxt = upc;
            SEQ_TWB: begin
                stk_pop = 1'b1;
                if (!r_zero) begin
                    if (!pass) begin
                        nxt     = tos;
                        r_dec   = 1'b1;
                        stk_pop = 1'b0;
                    end
                end else if (!pass) begin
                    nxt = d;
                end
            end
            default: nxt = upc;
        endcase
        // Reset points mcrom at address 0 regardless of the microword
        if (rst) nxt = '0;
    end

    assign addr   = nxt;
    assign map_oe = (instr == SEQ_JMAP);
    assign vec_oe = (instr == SEQ_CJV);

    am4_useq_stack #(
        .AW     (AW),
        .SDEPTH (SDEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .ena   (ena),
        .push  (stk_push),
        .pop   (stk_pop),
        .clr   (stk_clr),
        .din   (upc),
        .tos   (tos),
        .full  (full),
        .empty (empty)
    );

    // Microprogram counter follows the address just issued, plus carry-in
    always_ff @(posedge clk) begin
        if (rst) begin
            upc <= '0;
        end else if (ena) begin
            upc <= addr + AW'(ci);
        end
    end

    // Loop counter: rld wins over any opcode load or decrement
    always_ff @(posedge clk) begin
        if (rst) begin
            r <= '0;
        end else if (ena) begin
            if (rld || r_load) begin
                r <= d;
            end else if (r_dec) begin
                r <= r - AW'(1);
            end
        end
    end

`ifdef M4_USEQ_STKERR_EN
    // Sticky flag for stack overflow (push while full) or underflow (pop while empty)
    always_ff @(posedge clk) begin
        if (rst) begin
            stk_err <= 1'b0;
        end else if (ena && ((stk_push && full) || (stk_pop && empty))) begin
            stk_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_am4_useq.sv
// Directed scoreboard bench for am4_useq: stimulus queues expected outputs, a monitor compares.
// Latency: each step drives one microword and expects the combinational outputs before the next edge.
// Backpressure: ena=0 steps check that addr and state stay frozen.
module tb_am4_useq;
    import am4_useq_pkg::*;

    localparam int AW = 10;
    localparam logic [AW-1:0] MAP_V  = 10'h2A5;
    localparam logic [AW-1:0] VECT_V = 10'h3C3;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic [3:0]    instr;
    logic [AW-1:0] d;
    logic [AW-1:0] map;
    logic [AW-1:0] vect;
    logic          cc;
    logic          ccen;
    logic          ci;
    logic          rld;
    logic [AW-1:0] addr;
    logic          map_oe;
    logic          vec_oe;
    logic          full;
`ifdef M4_USEQ_STKERR_EN
    logic          stk_err;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          full;
        logic          map_oe;
        logic          vec_oe;
        logic          err;
        string         nm;
    } exp_t;

    exp_t exp_q[$];

    am4_useq #(.AW(AW), .SDEPTH(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .instr  (instr),
        .d      (d),
        .map    (map),
        .vect   (vect),
        .cc     (cc),
        .ccen   (ccen),
        .ci     (ci),
        .rld    (rld),
        .addr   (addr),
        .map_oe (map_oe),
        .vec_oe (vec_oe),
        .full   (full)
`ifdef M4_USEQ_STKERR_EN
        ,
        .stk_err(stk_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=0x%0h required=0x%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation, mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk(e.nm, "addr", 32'(addr), 32'(e.addr));
                chk(e.nm, "full", 32'(full), 32'(e.full));
                chk(e.nm, "map_oe", 32'(map_oe), 32'(e.map_oe));
                chk(e.nm, "vec_oe", 32'(vec_oe), 32'(e.vec_oe));
`ifdef M4_USEQ_STKERR_EN
                chk(e.nm, "stk_err", 32'(stk_err), 32'(e.err));
`endif
            end
        end
    end

    // Drive one microword, queue the hand-computed response, advance to just after the edge
    task automatic step(input logic [3:0] op, input logic [AW-1:0] dv, input logic c, input logic ce,
                        input logic en, input logic rs, input logic rl,
                        input logic [AW-1:0] ea, input logic ef, input logic ee, input string nm);
        exp_t e;
        instr = op;
        d     = dv;
        cc    = c;
        ccen  = ce;
        ena   = en;
        rst   = rs;
        rld   = rl;
        e.addr   = ea;
        e.full   = ef;
        e.map_oe = (op == SEQ_JMAP);
        e.vec_oe = (op == SEQ_CJV);
        e.err    = ee;
        e.nm     = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; instr = SEQ_CONT; d = '0; map = MAP_V; vect = VECT_V;
        cc = 1'b0; ccen = 1'b0; ci = 1'b1; rld = 1'b0;
        @(posedge clk);
        #1;
        //   op        d       cc ce en rs rl  addr    full err  name
        step(SEQ_CONT, 10'h000, 0, 0, 1, 1, 0, 10'h000, 0, 0, "rst_a");
        step(SEQ_CONT, 10'h000, 0, 0, 1, 1, 0, 10'h000, 0, 0, "rst_b");
        step(SEQ_CONT, 10'h000, 0, 0, 1, 0, 0, 10'h000, 0, 0, "cont0");
        step(SEQ_CONT, 10'h000, 0, 0, 1, 0, 0, 10'h001, 0, 0, "cont1");
        step(SEQ_CONT, 10'h000, 0, 0, 1, 0, 0, 10'h002, 0, 0, "cont2");
        step(SEQ_CONT, 10'h000, 0, 0, 1, 0, 0, 10'h003, 0, 0, "cont3");
        step(SEQ_CJP,  10'h00F, 0, 0, 1, 0, 0, 10'h00F, 0, 0, "cjp_pass");
        step(SEQ_CJS,  10'h155, 0, 0, 1, 0, 0, 10'h155, 0, 0, "cjs_pass");
        step(SEQ_CRTN, 10'h000, 0, 0, 1, 0, 0, 10'h010, 0, 0, "crtn_ret");
        step(SEQ_LOOP, 10'h000, 0, 1, 1, 0, 0, 10'h000, 0, 0, "loop_empty");
        step(SEQ_CJV,  10'h000, 0, 1, 1, 0, 0, 10'h001, 0, 0, "cjv_fail");
        step(SEQ_CJV,  10'h000, 1, 1, 1, 0, 0, 10'h3C3, 0, 0, "cjv_pass");
        step(SEQ_JMAP, 10'h000, 0, 0, 1, 0, 0, 10'h2A5, 0, 0, "jmap");
        step(SEQ_CJP,  10'h100, 0, 1, 1, 0, 0, 10'h2A6, 0, 0, "cjp_fail");
        step(SEQ_LDCT, 10'h003, 0, 0, 1, 0, 0, 10'h2A7, 0, 0, "ldct3");
        step(SEQ_RPCT, 10'h020, 0, 0, 1, 0, 0, 10'h020, 0, 0, "rpct_r3");
        step(SEQ_RPCT, 10'h020, 0, 0, 1, 0, 0, 10'h020, 0, 0, "rpct_r2");
        step(SEQ_RPCT, 10'h020, 0, 0, 1, 0, 0, 10'h020, 0, 0, "rpct_r1");
        step(SEQ_RPCT, 10'h020, 0, 0, 1, 0, 0, 10'h021, 0, 0, "rpct_r0");
        step(SEQ_JRP,  10'h111, 0, 1, 1, 0, 0, 10'h000, 0, 0, "r_is_zero");
        step(SEQ_CONT, 10'h0AB, 0, 0, 1, 0, 1, 10'h001, 0, 0, "rld_cont");
        step(SEQ_JRP,  10'h111, 0, 1, 1, 0, 0, 10'h0AB, 0, 0, "r_after_rld");
        step(SEQ_PUSH, 10'h002, 0, 0, 1, 0, 0, 10'h0AC, 0, 0, "push_ld2");
        step(SEQ_CONT, 10'h000, 0, 0, 1, 0, 0, 10'h0AD, 0, 0, "body_a");
        step(SEQ_RFCT, 10'h000, 0, 0, 1, 0, 0, 10'h0AC, 0, 0, "rfct_r2");
        for (int i = 0; i < 4; i++) begin
            step(SEQ_RFCT, 10'h000, 0, 0, 0, 0, 0, 10'h0AC, 0, 0, "ena_freeze");
        end
        step(SEQ_CONT, 10'h000, 0, 0, 1, 0, 0, 10'h0AD, 0, 0, "body_b");
        step(SEQ_RFCT, 10'h000, 0, 0, 1, 0, 0, 10'h0AC, 0, 0, "rfct_r1");
        step(SEQ_CONT, 10'h000, 0, 0, 1, 0, 0, 10'h0AD, 0, 0, "body_c");
        step(SEQ_RFCT, 10'h000, 0, 0, 1, 0, 0, 10'h0AE, 0, 0, "rfct_exit");
        step(SEQ_LOOP, 10'h000, 0, 1, 1, 0, 0, 10'h000, 0, 0, "rfct_popped");
        step(SEQ_PUSH, 10'h000, 0, 1, 1, 0, 0, 10'h001, 0, 0, "push1");
        step(SEQ_PUSH, 10'h000, 0, 1, 1, 0, 0, 10'h002, 0, 0, "push2");
        step(SEQ_PUSH, 10'h000, 0, 1, 1, 0, 0, 10'h003, 0, 0, "push3");
        step(SEQ_PUSH, 10'h000, 0, 1, 1, 0, 0, 10'h004, 0, 0, "push4");
        step(SEQ_PUSH, 10'h000, 0, 1, 1, 0, 0, 10'h005, 0, 0, "push5");
        step(SEQ_PUSH, 10'h000, 0, 1, 1, 0, 0, 10'h006, 1, 0, "push6_full");
        step(SEQ_CRTN, 10'h000, 0, 0, 1, 0, 0, 10'h006, 1, 1, "tos_overwritten");
        step(SEQ_CRTN, 10'h000, 0, 0, 1, 0, 0, 10'h004, 0, 1, "pop_below");
        step(SEQ_JZ,   10'h077, 0, 0, 1, 0, 1, 10'h000, 0, 1, "jz_rld");
        step(SEQ_LOOP, 10'h000, 0, 1, 1, 0, 0, 10'h000, 0, 1, "jz_cleared_sp");
        step(SEQ_JRP,  10'h000, 0, 1, 1, 0, 0, 10'h077, 0, 1, "jz_loaded_r");
        step(SEQ_CJS,  10'h200, 0, 0, 1, 0, 0, 10'h200, 0, 1, "cjs_sub");
        step(SEQ_CONT, 10'h000, 0, 0, 1, 1, 0, 10'h000, 0, 1, "rst_mid_sub");
        step(SEQ_LOOP, 10'h000, 0, 1, 1, 0, 0, 10'h000, 0, 0, "stack_discarded");
        step(SEQ_JRP,  10'h000, 0, 1, 1, 0, 0, 10'h000, 0, 0, "r_reset");
        step(SEQ_PUSH, 10'h000, 0, 1, 1, 0, 0, 10'h001, 0, 0, "twb_push");
        step(SEQ_LDCT, 10'h001, 0, 0, 1, 0, 0, 10'h002, 0, 0, "twb_ldct");
        step(SEQ_TWB,  10'h155, 0, 1, 1, 0, 0, 10'h001, 0, 0, "twb_r1_fail");
        step(SEQ_TWB,  10'h155, 0, 1, 1, 0, 0, 10'h155, 0, 0, "twb_r0_fail");
        step(SEQ_LOOP, 10'h000, 0, 1, 1, 0, 0, 10'h000, 0, 0, "twb_popped");

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
